// File: rtl/dma_block_mover.sv
// Single-master block copier: read-capture-write bus cycles, one byte per 3 clocks.
// Optional DMA_FILL_EN adds a fill mode that writes a constant byte at 1 clock per byte.
module dma_block_mover #(
    parameter int ADDR_MIN = 64,
    parameter int ADDR_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] count,
`ifdef DMA_FILL_EN
    input  logic       fill_mode,
    input  logic [7:0] fill_data,
`endif
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] Address,
    output logic       MemRead,
    output logic       Enable,
    output logic       DB_tri,
    inout  wire logic [7:0] DB_io
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    localparam logic [8:0] MIN9 = ADDR_MIN[8:0];
    localparam logic [8:0] MAX9 = ADDR_MAX[8:0];

    logic [2:0] r_state;
    logic [7:0] r_src;
    logic [7:0] r_dst;
    logic [7:0] r_rem;
    logic [7:0] r_data;
    logic       r_fill;

    logic [8:0] w_srcEnd;
    logic [8:0] w_dstEnd;
    logic       w_srcBad;
    logic       w_dstBad;
    logic       w_rangeBad;
    logic       w_fillReq;

    // End addresses are 9 bits wide so a block running past 255 cannot wrap into range.
    assign w_srcEnd = {1'b0, src_addr} + {1'b0, count} - 9'd1;
    assign w_dstEnd = {1'b0, dst_addr} + {1'b0, count} - 9'd1;
    assign w_srcBad = ({1'b0, src_addr} < MIN9) || (w_srcEnd > MAX9);
    assign w_dstBad = ({1'b0, dst_addr} < MIN9) || (w_dstEnd > MAX9);

`ifdef DMA_FILL_EN
    assign w_fillReq = fill_mode;
`else
    assign w_fillReq = 1'b0;
`endif

    // A fill transfer never reads memory, so its source address is irrelevant.
    assign w_rangeBad = (w_srcBad && !w_fillReq) || w_dstBad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_src   <= 8'd0;
            r_dst   <= 8'd0;
            r_rem   <= 8'd0;
            r_data  <= 8'd0;
            r_fill  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (count == 8'd0) begin
                            r_state <= DONE;
                        end else if (w_rangeBad) begin
                            r_state <= ERR;
                        end else begin
                            r_src  <= src_addr;
                            r_dst  <= dst_addr;
                            r_rem  <= count;
                            r_fill <= w_fillReq;
`ifdef DMA_FILL_EN
                            if (fill_mode) begin
                                r_data  <= fill_data;
                                r_state <= WR;
                            end else begin
                                r_state <= RD;
                            end
`else
                            r_state <= RD;
`endif
                        end
                    end
                end
                RD: r_state <= CAP;
                CAP: begin
                    r_data  <= DB_io;
                    r_state <= WR;
                end
                // The memory commits the byte on this same edge, so pointers advance here.
                WR: begin
                    r_src <= r_src + 8'd1;
                    r_dst <= r_dst + 8'd1;
                    r_rem <= r_rem - 8'd1;
                    if (r_rem == 8'd1)
                        r_state <= DONE;
                    else if (r_fill)
                        r_state <= WR;
                    else
                        r_state <= RD;
                end
                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Address = 8'd0;
        case (r_state)
            RD, CAP: Address = r_src;
            WR:      Address = r_dst;
            default: Address = 8'd0;
        endcase
    end

    assign Enable  = (r_state == RD) || (r_state == WR);
    assign MemRead = (r_state == RD);
    assign DB_tri  = (r_state == RD) || (r_state == CAP);
    assign busy    = (r_state == RD) || (r_state == CAP) || (r_state == WR);
    assign done    = (r_state == DONE);
    assign err     = (r_state == ERR);

    // Only WR drives the bus, and DB_tri is low in WR, so the two drivers never overlap.
    assign DB_io = (r_state == WR) ? r_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_dma_block_mover.sv
// Directed self-checking bench for dma_block_mover with a behavioural memory responder.
// Define DMA_FILL_EN to also exercise the fill-mode path.
module tb_dma_block_mover;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] cnt;
`ifdef DMA_FILL_EN
    logic       fillMode;
    logic [7:0] fillData;
`endif
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] address;
    logic       memRead;
    logic       enable;
    logic       dbTri;
    wire  [7:0] dbBus;

    logic [7:0] mem [0:255];
    logic [7:0] memOut;
    logic       memInit;

    int testsRun = 0;
    int testsFailed = 0;

    int busyCycles = 0;
    int doneCycles = 0;
    int errCycles = 0;
    int enableCycles = 0;
    int readCycles = 0;
    int clashCycles = 0;

    dma_block_mover dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src),
        .dst_addr (dst),
        .count    (cnt),
`ifdef DMA_FILL_EN
        .fill_mode(fillMode),
        .fill_data(fillData),
`endif
        .busy     (busy),
        .done     (done),
        .err      (err),
        .Address  (address),
        .MemRead  (memRead),
        .Enable   (enable),
        .DB_tri   (dbTri),
        .DB_io    (dbBus)
    );

    always #5 clk = ~clk;

    // Memory responder: read data appears the cycle after the RD edge, writes commit at the WR edge.
    assign dbBus = dbTri ? memOut : 8'bzzzz_zzzz;

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            memOut <= 8'd0;
        end else begin
            if (enable && memRead) memOut <= mem[address];
            if (enable && !memRead) mem[address] <= dbBus;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busyCycles++;
            if (done) doneCycles++;
            if (err) errCycles++;
            if (enable) enableCycles++;
            if (enable && memRead) readCycles++;
            if (dbTri && enable && !memRead) clashCycles++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    // Pulses start for one edge and returns the edge index (1 = accept edge) at which done/err is seen.
    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d, input logic [7:0] c,
                                 output int doneEdge, output int errEdge);
        doneEdge = -1;
        errEdge  = -1;
        @(negedge clk);
        src = s;
        dst = d;
        cnt = c;
        start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done && doneEdge < 0) doneEdge = k;
            if (err && errEdge < 0) errEdge = k;
            if (doneEdge > 0 || errEdge > 0) break;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    int dEdge;
    int eEdge;
    int busy0, done0, err0, en0, rd0;

    initial begin
        reset = 1'b1;
        memInit = 1'b1;
        start = 1'b0;
        src = 8'd0;
        dst = 8'd0;
        cnt = 8'd0;
`ifdef DMA_FILL_EN
        fillMode = 1'b0;
        fillData = 8'd0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_outputs", {24'd0, busy, done, err, enable, memRead, dbTri, 2'b00},
                    32'd0);
        checkOutput("reset_address", {24'd0, address}, 32'd0);
        memInit = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Source below ADDR_MIN is rejected without touching the bus.
        busy0 = busyCycles; err0 = errCycles; en0 = enableCycles;
        applyStimulus(8'd10, 8'd128, 8'd2, dEdge, eEdge);
        checkOutput("lowsrc_err_edge", 32'(eEdge), 32'd1);
        checkOutput("lowsrc_done_edge", 32'(dEdge), 32'hFFFF_FFFF);
        checkOutput("lowsrc_err_pulses", 32'(errCycles - err0), 32'd1);
        checkOutput("lowsrc_enable", 32'(enableCycles - en0), 32'd0);
        checkOutput("lowsrc_busy", 32'(busyCycles - busy0), 32'd0);
        checkOutput("lowsrc_mem128", {24'd0, mem[128]}, 32'd128);
        checkOutput("lowsrc_mem129", {24'd0, mem[129]}, 32'd129);

        // Basic 4-byte copy: done seen after edge 3N+1 = 13, busy for 3N = 12 cycles.
        busy0 = busyCycles; done0 = doneCycles;
        applyStimulus(8'd64, 8'd128, 8'd4, dEdge, eEdge);
        checkOutput("main_done_edge", 32'(dEdge), 32'd13);
        checkOutput("main_busy_cycles", 32'(busyCycles - busy0), 32'd12);
        checkOutput("main_done_pulses", 32'(doneCycles - done0), 32'd1);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("main_mem%0d", 128 + i), {24'd0, mem[128 + i]}, 32'(64 + i));
        checkOutput("main_mem132", {24'd0, mem[132]}, 32'd132);

        // Destination end 250+8-1 = 257 overflows the map.
        en0 = enableCycles; err0 = errCycles;
        applyStimulus(8'd64, 8'd250, 8'd8, dEdge, eEdge);
        checkOutput("ovf_err_edge", 32'(eEdge), 32'd1);
        checkOutput("ovf_err_pulses", 32'(errCycles - err0), 32'd1);
        checkOutput("ovf_enable", 32'(enableCycles - en0), 32'd0);
        checkOutput("ovf_mem250", {24'd0, mem[250]}, 32'd250);

        // Exactly reaching 255 is legal.
        applyStimulus(8'd64, 8'd250, 8'd6, dEdge, eEdge);
        checkOutput("edge255_done_edge", 32'(dEdge), 32'd19);
        checkOutput("edge255_err_edge", 32'(eEdge), 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("edge255_mem%0d", 250 + i), {24'd0, mem[250 + i]}, 32'(64 + i));

        // Zero-length transfer completes immediately with no bus cycle.
        en0 = enableCycles; done0 = doneCycles;
        applyStimulus(8'd64, 8'd128, 8'd0, dEdge, eEdge);
        checkOutput("zero_done_edge", 32'(dEdge), 32'd1);
        checkOutput("zero_done_pulses", 32'(doneCycles - done0), 32'd1);
        checkOutput("zero_enable", 32'(enableCycles - en0), 32'd0);

        // 8-byte copy to 160, stray start after edge 4, reset during the third WR (after edge 9).
        @(negedge clk);
        src = 8'd64; dst = 8'd160; cnt = 8'd8; start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k == 4) begin
                src = 8'd70; dst = 8'd100; cnt = 8'd3; start = 1'b1;
            end
        end
        checkOutput("midrst_busy_before", {31'd0, busy}, 32'd1);
        checkOutput("midrst_in_write", {30'd0, enable, memRead}, 32'b10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_outputs", {24'd0, busy, done, err, enable, memRead, dbTri, 2'b00}, 32'd0);
        checkOutput("midrst_address", {24'd0, address}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("midrst_mem%0d", 160 + i), {24'd0, mem[160 + i]}, 32'(64 + i));
        for (int i = 3; i < 8; i++)
            checkOutput($sformatf("midrst_mem%0d", 160 + i), {24'd0, mem[160 + i]}, 32'(160 + i));
        checkOutput("stray_start_mem100", {24'd0, mem[100]}, 32'd100);

        // Fresh transfer after the abandoned one.
        applyStimulus(8'd70, 8'd170, 8'd3, dEdge, eEdge);
        checkOutput("fresh_done_edge", 32'(dEdge), 32'd10);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("fresh_mem%0d", 170 + i), {24'd0, mem[170 + i]}, 32'(70 + i));

`ifdef DMA_FILL_EN
        // Fill: N+1 = 6 edges to done, no read cycles, source not range-checked.
        rd0 = readCycles;
        fillMode = 1'b1;
        fillData = 8'hA5;
        applyStimulus(8'd0, 8'd200, 8'd5, dEdge, eEdge);
        fillMode = 1'b0;
        checkOutput("fill_done_edge", 32'(dEdge), 32'd6);
        checkOutput("fill_reads", 32'(readCycles - rd0), 32'd0);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("fill_mem%0d", 200 + i), {24'd0, mem[200 + i]}, 32'hA5);
        checkOutput("fill_mem205", {24'd0, mem[205]}, 32'd205);
`else
        rd0 = readCycles;
`endif

        checkOutput("bus_contention", 32'(clashCycles), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
